// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, registered response LATENCY cycles after accept.
// A memory-mapped tohost word sits at TOHOST_ADDR and pulses tohost_val_o on every store to it.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_val_i,
    output logic        req_rdy_o,
    input  logic        req_rw_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        resp_val_o,
    output logic [31:0] resp_data_o,
    output logic        resp_err_o,
    output logic        tohost_val_o,
    output logic [31:0] tohost_data_o,
    output logic [1:0]  dbg_state_o
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    // Handshake: a request transfers on a rising edge where req_val_i && req_rdy_o;
    // req_rdy_o depends on state only and req_val_i may drop without a transfer.
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

    state_e        state_q;
    logic [2:0]    cnt_q;
    logic          rw_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          resp_val_q;
    logic [31:0]   resp_data_q;
    logic          resp_err_q;
    logic          tohost_val_q;
    logic [31:0]   tohost_data_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          accept;
    logic          direct;
    logic          commit;
    logic          c_rw;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [3:0]    c_be;
    logic          c_tohost;
    logic          c_fault;
    logic [AW-1:0] c_idx;
    logic [31:0]   th_merged_d;
    logic          mem_we;

    assign req_rdy_o = (state_q != WAIT);
    assign accept    = req_val_i && req_rdy_o;

    // With LATENCY=1 the request commits on its own accepting edge, straight from the inputs.
    assign direct  = accept && (LATENCY == 1);
    assign commit  = direct || ((state_q == WAIT) && (cnt_q == 3'd0));
    assign c_rw    = direct ? req_rw_i    : rw_q;
    assign c_addr  = direct ? req_addr_i  : addr_q;
    assign c_wdata = direct ? req_wdata_i : wdata_q;
    assign c_be    = direct ? req_be_i    : be_q;

    assign c_tohost = (c_addr == TOHOST_ADDR);
    assign c_fault  = (c_addr[1:0] != 2'b00) ||
                      (!c_tohost && ({2'b00, c_addr[31:2]} >= DEPTH_WORDS));
    assign c_idx    = c_addr[AW+1:2];

    always_comb begin
        th_merged_d = tohost_data_q;
        for (int i = 0; i < 4; i++) begin
            if (c_be[i]) th_merged_d[8*i +: 8] = c_wdata[8*i +: 8];
        end
    end

    // Array is not reset; writes are suppressed while reset is held.
    assign mem_we = rst_ni && commit && c_rw && !c_fault && !c_tohost;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) mem_q[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            rw_q          <= 1'b0;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            be_q          <= 4'h0;
            resp_val_q    <= 1'b0;
            resp_data_q   <= 32'h0;
            resp_err_q    <= 1'b0;
            tohost_val_q  <= 1'b0;
            tohost_data_q <= 32'h0;
        end else begin
            if (accept) begin
                rw_q    <= req_rw_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                be_q    <= req_be_i;
            end
            resp_val_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            tohost_val_q <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 3'(LATENCY - 2);
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q == 3'd0) state_q <= RESP;
                    else               cnt_q   <= cnt_q - 3'd1;
                end
                default: state_q <= IDLE;
            endcase
            if (commit) begin
                resp_val_q <= 1'b1;
                if (c_fault) begin
                    resp_err_q  <= 1'b1;
                    resp_data_q <= 32'h0;
                end else if (c_tohost) begin
                    if (c_rw) begin
                        tohost_data_q <= th_merged_d;
                        tohost_val_q  <= 1'b1;
                        resp_data_q   <= 32'h0;
                    end else begin
                        resp_data_q <= tohost_data_q;
                    end
                end else begin
                    resp_data_q <= c_rw ? 32'h0 : mem_q[c_idx];
                end
            end
        end
    end

    assign resp_val_o    = resp_val_q;
    assign resp_data_o   = resp_data_q;
    assign resp_err_o    = resp_err_q;
    assign tohost_val_o  = tohost_val_q;
    assign tohost_data_o = tohost_data_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances at LATENCY 1, 3 and 4 share one clock,
// directed scenarios plus randomized traffic checked against a word/byte memory model.
module tb_dmem_responder;
    localparam int N  = 3;
    localparam int DW = 256;

    logic        clk = 1'b0;
    logic        rst_n       [N];
    logic        req_val     [N];
    logic        req_rdy     [N];
    logic        req_rw      [N];
    logic [31:0] req_addr    [N];
    logic [31:0] req_wdata   [N];
    logic [3:0]  req_be      [N];
    logic        resp_val    [N];
    logic [31:0] resp_data   [N];
    logic        resp_err    [N];
    logic        tohost_val  [N];
    logic [31:0] tohost_data [N];
    logic [1:0]  dbg_state   [N];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(DW),
            .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .TOHOST_ADDR(32'h0000_1000)
        ) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n[g]),
            .req_val_i    (req_val[g]),
            .req_rdy_o    (req_rdy[g]),
            .req_rw_i     (req_rw[g]),
            .req_addr_i   (req_addr[g]),
            .req_wdata_i  (req_wdata[g]),
            .req_be_i     (req_be[g]),
            .resp_val_o   (resp_val[g]),
            .resp_data_o  (resp_data[g]),
            .resp_err_o   (resp_err[g]),
            .tohost_val_o (tohost_val[g]),
            .tohost_data_o(tohost_data[g]),
            .dbg_state_o  (dbg_state[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Issues one request; returns in the cycle resp_val is seen (or the bound expires).
    task automatic xact(input int d, input logic rw, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic err,
                        output logic tv, output int lat);
        int n;
        req_val[d] = 1'b1; req_rw[d] = rw; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
        n = 0;
        while (!req_rdy[d] && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_val[d] = 1'b0;
        lat = 1;
        while (!resp_val[d] && lat < 10) begin @(posedge clk); #1; lat++; end
        rd = resp_data[d]; err = resp_err[d]; tv = tohost_val[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < N; d++) begin
            n_cmp++;
            if ({req_rdy[d], resp_val[d], resp_err[d], tohost_val[d], resp_data[d], tohost_data[d]}
                !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
                n_bad++;
                $display("FAIL reset[%0d]: rdy=%b val=%b err=%b tv=%b data=%h th=%h, want 1 0 0 0 0 0",
                         d, req_rdy[d], resp_val[d], resp_err[d], tohost_val[d], resp_data[d], tohost_data[d]);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic err, tv; int lat;
        xact(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, rd, err, tv, lat);
        n_cmp++;
        if ({lat, err, rd} !== {32'd1, 1'b0, 32'h0}) begin
            n_bad++; $display("FAIL basic_store: lat=%0d err=%b data=%h, want 1 0 0", lat, err, rd);
        end
        xact(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, err, tv, lat);
        n_cmp++;
        if ({lat, err, rd} !== {32'd1, 1'b0, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL basic_load: lat=%0d err=%b data=%h, want 1 0 deadbeef", lat, err, rd);
        end
    endtask

    task automatic test_byte_en();
        logic [31:0] rd; logic err, tv; int lat;
        xact(0, 1'b1, 32'h44, 32'hDEADBEEF, 4'hF, rd, err, tv, lat);
        xact(0, 1'b1, 32'h44, 32'h00000011, 4'b0001, rd, err, tv, lat);
        xact(0, 1'b0, 32'h44, 32'h0, 4'h0, rd, err, tv, lat);
        n_cmp++;
        if (rd !== 32'hDEADBE11) begin
            n_bad++; $display("FAIL byte_en_lane0: got %h want deadbe11", rd);
        end
        xact(0, 1'b1, 32'h44, 32'hAABB0000, 4'b1100, rd, err, tv, lat);
        xact(0, 1'b0, 32'h44, 32'h0, 4'h0, rd, err, tv, lat);
        n_cmp++;
        if (rd !== 32'hAABBBE11) begin
            n_bad++; $display("FAIL byte_en_upper: got %h want aabbbe11", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic        rws [3];
        logic [31:0] ads [3];
        logic [31:0] wds [3];
        logic [9:0]  got_rdy, got_val;
        logic [31:0] last;
        logic        acc;
        int          k;
        rws = '{1'b1, 1'b1, 1'b0};
        ads = '{32'h10, 32'h14, 32'h10};
        wds = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0};
        @(posedge clk); #1;
        k = 0;
        req_val[1] = 1'b1; req_rw[1] = rws[0]; req_addr[1] = ads[0]; req_wdata[1] = wds[0]; req_be[1] = 4'hF;
        last = 32'h0;
        for (int c = 0; c < 10; c++) begin
            got_rdy[c] = req_rdy[1];
            got_val[c] = resp_val[1];
            if (c == 9) last = resp_data[1];
            acc = req_rdy[1] && req_val[1];
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k == 3) req_val[1] = 1'b0;
                else begin
                    req_rw[1] = rws[k]; req_addr[1] = ads[k]; req_wdata[1] = wds[k];
                end
            end
        end
        n_cmp++;
        if (got_rdy !== 10'b1001001001) begin
            n_bad++; $display("FAIL b2b_rdy: got %b want 1001001001 (bit c = cycle c)", got_rdy);
        end
        n_cmp++;
        if (got_val !== 10'b1001001000) begin
            n_bad++; $display("FAIL b2b_resp_val: got %b want 1001001000 (bit c = cycle c)", got_val);
        end
        n_cmp++;
        if (last !== 32'h1234_5678) begin
            n_bad++; $display("FAIL b2b_load: got %h want 12345678", last);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd; logic err, tv; int lat;
        xact(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, err, tv, lat);
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, tv, lat);
        n_cmp++;
        if ({err, rd} !== {1'b0, 32'hCAFEF00D}) begin
            n_bad++; $display("FAIL fault_pre_load: err=%b data=%h want 0 cafef00d", err, rd);
        end
        xact(0, 1'b0, 32'h42, 32'h0, 4'h0, rd, err, tv, lat);
        n_cmp++;
        if ({lat, err, rd} !== {32'd1, 1'b1, 32'h0}) begin
            n_bad++; $display("FAIL fault_misaligned: lat=%0d err=%b data=%h want 1 1 0", lat, err, rd);
        end
        xact(0, 1'b1, DW * 4, 32'h5555_AAAA, 4'hF, rd, err, tv, lat);
        n_cmp++;
        if ({err, rd} !== {1'b1, 32'h0}) begin
            n_bad++; $display("FAIL fault_range_store: err=%b data=%h want 1 0", err, rd);
        end
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, tv, lat);
        n_cmp++;
        if ({err, rd} !== {1'b0, 32'hCAFEF00D}) begin
            n_bad++; $display("FAIL fault_word0_kept: err=%b data=%h want 0 cafef00d", err, rd);
        end
    endtask

    task automatic test_tohost();
        logic [31:0] rd; logic err, tv; int lat;
        xact(0, 1'b1, 32'h1000, 32'h1, 4'hF, rd, err, tv, lat);
        n_cmp++;
        if ({tv, err, rd, tohost_data[0]} !== {1'b1, 1'b0, 32'h0, 32'h1}) begin
            n_bad++; $display("FAIL tohost_store: tv=%b err=%b data=%h th=%h want 1 0 0 1", tv, err, rd, tohost_data[0]);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({tohost_val[0], resp_val[0]} !== 2'b00) begin
            n_bad++; $display("FAIL tohost_pulse_len: tv=%b val=%b next cycle, want 0 0", tohost_val[0], resp_val[0]);
        end
        xact(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, err, tv, lat);
        n_cmp++;
        if ({tv, err, rd} !== {1'b0, 1'b0, 32'h1}) begin
            n_bad++; $display("FAIL tohost_load: tv=%b err=%b data=%h want 0 0 1", tv, err, rd);
        end
        xact(0, 1'b1, 32'h1000, 32'hAB00_0000, 4'b1000, rd, err, tv, lat);
        n_cmp++;
        if (tohost_data[0] !== 32'hAB00_0001) begin
            n_bad++; $display("FAIL tohost_masked: th=%h want ab000001", tohost_data[0]);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic err, tv; int lat; logic saw;
        xact(2, 1'b1, 32'h80, 32'h1122_3344, 4'hF, rd, err, tv, lat);
        n_cmp++;
        if ({lat, err} !== {32'd4, 1'b0}) begin
            n_bad++; $display("FAIL midop_pre_store: lat=%0d err=%b want 4 0", lat, err);
        end
        req_val[2] = 1'b1; req_rw[2] = 1'b1; req_addr[2] = 32'h80; req_wdata[2] = 32'h5555_5555; req_be[2] = 4'hF;
        @(posedge clk); #1;
        req_val[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n[2] = 1'b0;
        #1;
        saw = resp_val[2];
        n_cmp++;
        if ({req_rdy[2], resp_val[2]} !== 2'b10) begin
            n_bad++; $display("FAIL midop_in_reset: rdy=%b val=%b want 1 0", req_rdy[2], resp_val[2]);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            saw = saw | resp_val[2];
        end
        rst_n[2] = 1'b1;
        #1;
        n_cmp++;
        if ({saw, req_rdy[2]} !== 2'b01) begin
            n_bad++; $display("FAIL midop_no_resp: saw_val=%b rdy=%b want 0 1", saw, req_rdy[2]);
        end
        @(posedge clk); #1;
        xact(2, 1'b0, 32'h80, 32'h0, 4'h0, rd, err, tv, lat);
        n_cmp++;
        if ({lat, err, rd} !== {32'd4, 1'b0, 32'h1122_3344}) begin
            n_bad++; $display("FAIL midop_load: lat=%0d err=%b data=%h want 4 0 11223344", lat, err, rd);
        end
    endtask

    task automatic test_random(input int d, input int n_ops);
        logic [31:0] mm [int];
        logic [31:0] th, a, wd, rd, exp_rd;
        logic [3:0]  be;
        logic        rw, err, tv, exp_err, exp_tv;
        int          lat, kind, w;
        th = $urandom;
        xact(d, 1'b1, 32'h1000, th, 4'hF, rd, err, tv, lat);
        for (int i = 0; i < 16; i++) begin
            mm[i] = $urandom;
            xact(d, 1'b1, 32'(i * 4), mm[i], 4'hF, rd, err, tv, lat);
        end
        for (int i = 0; i < n_ops; i++) begin
            kind = $urandom_range(0, 9);
            w    = $urandom_range(0, 15);
            rw   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            if (kind <= 5)      a = 32'(w * 4);
            else if (kind == 6) a = 32'(w * 4 + $urandom_range(1, 3));
            else if (kind == 7) a = ($urandom_range(0, 1) != 0) ? 32'(DW * 4 + w * 4) : 32'h8000_0000 + 32'(w * 4);
            else                a = 32'h1000;
            exp_err = 1'b0; exp_tv = 1'b0; exp_rd = 32'h0;
            if ((a % 4) != 0 || (a != 32'h1000 && a >= DW * 4)) begin
                exp_err = 1'b1;
            end else if (a == 32'h1000) begin
                if (rw) begin th = merge(th, wd, be); exp_tv = 1'b1; end
                else exp_rd = th;
            end else begin
                if (rw) mm[int'(a / 4)] = merge(mm[int'(a / 4)], wd, be);
                else exp_rd = mm[int'(a / 4)];
            end
            xact(d, rw, a, wd, be, rd, err, tv, lat);
            n_cmp++;
            if ({lat, err, tv, rd, tohost_data[d]} !== {lat_of(d), exp_err, exp_tv, exp_rd, th}) begin
                n_bad++;
                $display("FAIL random[%0d] op%0d rw=%b a=%h be=%h: lat=%0d err=%b tv=%b data=%h th=%h want %0d %b %b %h %h",
                         d, i, rw, a, be, lat, err, tv, rd, tohost_data[d], lat_of(d), exp_err, exp_tv, exp_rd, th);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < N; d++) begin
            rst_n[d] = 1'b0; req_val[d] = 1'b0; req_rw[d] = 1'b0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0; req_be[d] = 4'h0;
        end
        #12;
        test_reset();
        @(posedge clk); #1;
        for (int d = 0; d < N; d++) rst_n[d] = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_byte_en();
        test_back_to_back();
        test_faults();
        test_tohost();
        test_reset_midop();
        test_random(0, 60);
        test_random(1, 40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the Chronos core's dmem request port: accepts load/store requests, holds one request in flight, and returns a registered response after a fixed, parameterised latency. It also decodes a memory-mapped tohost word so a store from the core raises a host-visible event. It sits in the test harness between `chronosCore` and the host side, alongside `inst_mem`.

## Interface
- `DEPTH_WORDS`, 1024 — number of 32-bit words in the backing array; must be a power of two.
- `LATENCY`, 1 — cycles from request acceptance to `resp_val`; legal range 1..7.
- `TOHOST_ADDR`, 32'h0000_1000 — byte address of the tohost register; word aligned.

- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — reset, asynchronous assert, active-low.
- `req_val` in 1 — request valid.
- `req_rdy` out 1 — responder can accept this cycle.
- `req_rw` in 1 — 0 = load, 1 = store.
- `req_addr` in 32 — byte address.
- `req_wdata` in 32 — store data.
- `req_be` in 4 — store byte enables; bit i enables `wdata[8i+7:8i]`. Ignored for loads.
- `resp_val` out 1 — one-cycle response strobe.
- `resp_data` out 32 — load data; 0 for stores and errors.
- `resp_err` out 1 — access fault, valid with `resp_val`.
- `tohost_val` out 1 — one-cycle pulse on a tohost store commit.
- `tohost_data` out 32 — last value stored to `TOHOST_ADDR`.

## Operation
- **States.** IDLE, WAIT, RESP.
- **Ready.** `req_rdy` is 1 in IDLE and RESP and 0 in WAIT. It is combinational from state only.
- **Accept.** A request is accepted when `req_val && req_rdy`. On accept, `rw`, `addr`, `wdata` and `be` are captured into internal registers.
- **Transitions.**
  - IDLE, accept: go to RESP if `LATENCY`=1, else go to WAIT with counter = `LATENCY`-2.
  - WAIT: decrement the counter; at 0, go to RESP.
  - RESP, accept: same destinations as IDLE.
  - RESP, no accept: go to IDLE.
- **Commit on the RESP cycle.** The captured request commits on the edge that enters RESP. Outputs are registered, so `resp_val` and the other response outputs are visible throughout the RESP cycle.
- **Fault check.** An access faults if `addr[1:0]` != 0, or if it is not `TOHOST_ADDR` and `addr[31:2]` >= `DEPTH_WORDS`. On a fault: `resp_err`=1, `resp_data`=0, no array or tohost write.
- **Tohost access.** Tohost decode has priority over the array.
  - Store: masked merge (per `be`) into `tohost_data`; `tohost_val`=1 for the RESP cycle; `resp_data`=0.
  - Load: returns `tohost_data`.
- **Array store.** Byte-masked write to word `addr[31:2]`. Lanes with `be` bit 0 are unchanged. `resp_data`=0.
- **Array load.** Returns the full word at `addr[31:2]`.
- **Ordering.** A commit occurs before any later-accepted request's commit, so read-after-write always returns the new data.
- **Reset.** Array contents are not reset (undefined until written).

## Timing
- **Reset values.** `req_rdy`=1 (state IDLE), `resp_val`=0, `resp_data`=0, `resp_err`=0, `tohost_val`=0, `tohost_data`=0.
- **Outside RESP.** `resp_val`, `resp_err` and `tohost_val` are 0. `resp_data` holds its last value and is only meaningful when `resp_val`=1.
- **Latency.** A request accepted in cycle N produces `resp_val`=1 in cycle N+`LATENCY`.
- **Throughput.** One request per `LATENCY` cycles, because back-to-back accept in RESP is allowed. `LATENCY`=1 sustains one request per cycle.
- **Handshake.** `req_val` may drop without acceptance; there is no obligation to hold it. Inputs are sampled only on the accepting edge.
- **Reset mid-operation.** Asserting `rst` in WAIT or RESP discards the pending request: no array or tohost update commits after reset assertion. Outputs go to reset values immediately (asynchronously). The first accept is possible in the first cycle after `rst` deasserts.
- **Simultaneous events.** Accepting in RESP while responding is legal. The new request's commit sees the array state including the current commit.

## Test plan
- **Basic store/load, `LATENCY`=1.** Store `0xDEADBEEF`, `be`=F to 0x40, then load 0x40 -> `resp_val` one cycle after each accept, load returns `0xDEADBEEF`, `resp_err`=0.
- **Byte enables.** Store `0xDEADBEEF` to 0x44, then store `0x00000011` with `be`=4'b0001, then load -> `0xDEADBE11`. Then store `0xAABB0000` with `be`=4'b1100, then load -> `0xAABBBE11`.
- **Latency and back-to-back, `LATENCY`=3.** Hold `req_val`=1 with three requests -> `req_rdy` pattern 1,0,0,1,0,0,1; `resp_val` in cycles 3, 6, 9 after the first accept.
- **Faults.** Load 0x42 -> `resp_err`=1, `resp_data`=0. Store to `DEPTH_WORDS`*4 -> `resp_err`=1, and a following load of word 0 is unchanged.
- **Tohost.** Store `0x00000001` to 0x1000 -> `tohost_val`=1 for exactly one cycle, coincident with `resp_val`; `tohost_data`=1. Load 0x1000 -> returns 1.
- **Reset mid-op, `LATENCY`=4.** Store to 0x80, then assert `rst` two cycles after accept -> no `resp_val`. After release, load 0x80 -> returns the prior value; `req_rdy`=1 during and after reset.
